// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
//   Shared types, constants and helpers for the sequential binary-to-BCD
//   converter and its optional 7-segment output stage.
//   Contents:
//     state_e      converter FSM states {IDLE, SHIFT, DONE}
//     DIGIT_W      bits per BCD digit
//     ADD3_THRESH  double-dabble correction threshold
//     SEG_BLANK    active-low pattern with every segment off
//     SEG_DASH     active-low pattern showing '-' (segment g only)
//     SEG_TABLE    16-entry active-low {dp,g..a} glyph table, 0-9 and A-F
//     add3()       per-digit double-dabble correction
//     pow10()      10**n, for the overflow limit
//     seg_lookup() SEG_TABLE indexed by a 4-bit digit
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] SEG_DASH    = 8'hBF;

  // Entry d lives in bits [8*d+7 : 8*d]; glyph 0 is the least significant byte.
  localparam logic [127:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Digits of 5 or more are bumped by 3 so the following left shift carries
  // into the next decimal digit instead of producing 10..15.
  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= ADD3_THRESH) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

  function automatic logic [7:0] seg_lookup(input logic [3:0] d);
    return SEG_TABLE[{d, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if
//   Handshake bundle between a requester and bin2bcd_seq.
//   Signals:
//     start     requester -> converter  conversion request (taken in IDLE only)
//     bin       requester -> converter  binary operand, BIN_W bits
//     busy      converter -> requester  conversion in progress
//     done      converter -> requester  one-cycle pulse, bcd/overflow just updated
//     bcd       converter -> requester  packed BCD, digit 0 in [3:0]
//     overflow  converter -> requester  operand did not fit in DIGITS digits
//   Modports: master (requester side), slave (converter side).
// ---------------------------------------------------------------------------
interface bin2bcd_seq_if
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
);

  logic                      start;
  logic [BIN_W-1:0]          bin;
  logic                      busy;
  logic                      done;
  logic [DIGIT_W*DIGITS-1:0] bcd;
  logic                      overflow;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output overflow
  );

endinterface

// File: rtl/bin2bcd_seq_seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
//   One BCD/hex digit to an active-low 7-segment pattern {dp,g,f,e,d,c,b,a},
//   bit order matching the DE10-Lite HEXn ports. dp is always off.
//   Ports:
//     i_digit  in   4  digit value 0..15
//     o_seg    out  8  active-low segment pattern
//   Purely combinational; the caller registers the result.
// ---------------------------------------------------------------------------
module seg7_decode
  import bin2bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [7:0] o_seg
);

  assign o_seg = seg_lookup(i_digit);

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential double-dabble binary-to-BCD converter feeding the HEX display
//   decode. One operand per BIN_W+2 cycles: start is taken in IDLE, BIN_W
//   shift cycles follow (busy high), one DONE cycle publishes the result, and
//   done pulses in the cycle after that, which is already back in IDLE.
//   Operands of 10**DIGITS or more set overflow and saturate bcd to all 9s.
//   Parameters:
//     BIN_W   binary operand width (>= 1)
//     DIGITS  BCD digits produced (1..6)
//   Ports:
//     MAX10_CLK1_50  in   1             clock, rising edge
//     reset          in   1             synchronous, active-high
//     bus            slave modport of bin2bcd_seq_if (start/bin/busy/done/
//                    bcd/overflow)
//     seg            out  8*DIGITS      only with BIN2BCD_SEG_OUT_EN: active-low
//                    {dp,g..a} per digit, loaded one cycle after done, '-' on
//                    every digit for overflow, all segments off after reset
//   Configuration macro: BIN2BCD_SEG_OUT_EN (adds seg and the segment decode).
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
)
(
  input  logic                  MAX10_CLK1_50,
  input  logic                  reset,
  bin2bcd_seq_if.slave          bus
`ifdef BIN2BCD_SEG_OUT_EN
  ,
  output logic [8*DIGITS-1:0]   seg
`endif
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  // One spare digit on top of the result so an oversized operand leaves a
  // visible trace above the published digits.
  localparam int ACC_W = BCD_W + DIGIT_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  // 10**6 needs 20 bits; 21 leaves headroom for the compare.
  localparam int CMP_W = (BIN_W > 21) ? BIN_W : 21;
  localparam bit OVF_POSSIBLE = (BIN_W >= 21) ||
                                ((64'd1 << BIN_W) > 64'(pow10(DIGITS)));

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin_sr;
  logic [ACC_W-1:0]   r_acc;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;

  state_e             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BIN_W-1:0]   w_sr_nxt;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic               w_ovf_nxt;
  logic [ACC_W-1:0]   w_acc_adj;
  logic               w_ovf;
  logic               w_unused_msb;

  // Add-3 correction applied to every accumulator digit ahead of the shift.
  always_comb begin
    w_acc_adj = r_acc;
    for (int d = 0; d <= DIGITS; d++) begin
      w_acc_adj[d*DIGIT_W +: DIGIT_W] = add3(r_acc[d*DIGIT_W +: DIGIT_W]);
    end
  end

  // The corrected top bit is shifted out and never needed.
  assign w_unused_msb = w_acc_adj[ACC_W-1];

  generate
    if (OVF_POSSIBLE) begin : g_ovf
      localparam logic [CMP_W-1:0] LIMIT = CMP_W'(pow10(DIGITS));
      logic [BIN_W-1:0] r_bin_cap;

      // Keeps the accepted operand for the range compare in DONE.
      always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
          r_bin_cap <= '0;
        end else if ((r_state == IDLE) && bus.start) begin
          r_bin_cap <= bus.bin;
        end else begin
          r_bin_cap <= r_bin_cap;
        end
      end

      assign w_ovf = (|r_acc[ACC_W-1:BCD_W]) || (CMP_W'(r_bin_cap) >= LIMIT);
    end else begin : g_no_ovf
      assign w_ovf = 1'b0;
    end
  endgenerate

  // FSM next state plus next values of the datapath and output registers.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_bin_sr;
    w_acc_nxt   = r_acc;
    w_done_nxt  = 1'b0;
    w_bcd_nxt   = r_bcd;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = SHIFT;
          w_sr_nxt    = bus.bin;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        w_acc_nxt = {w_acc_adj[ACC_W-2:0], r_bin_sr[BIN_W-1]};
        w_sr_nxt  = r_bin_sr << 1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        if (w_ovf) begin
          w_bcd_nxt = {DIGITS{4'h9}};
          w_ovf_nxt = 1'b1;
        end else begin
          w_bcd_nxt = r_acc[BCD_W-1:0];
          w_ovf_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == SHIFT);
  end

  // State, datapath and output registers; reset aborts any conversion.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bin_sr <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bin_sr <= w_sr_nxt;
      r_acc    <= w_acc_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_bcd    <= w_bcd_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_ovf;

`ifdef BIN2BCD_SEG_OUT_EN
  logic [8*DIGITS-1:0] w_seg_dec;
  logic [8*DIGITS-1:0] r_seg;

  for (genvar gd = 0; gd < DIGITS; gd++) begin : g_seg
    seg7_decode u_seg7_decode (
      .i_digit (r_bcd[gd*DIGIT_W +: DIGIT_W]),
      .o_seg   (w_seg_dec[gd*8 +: 8])
    );
  end

  // Segment image reloads only when a fresh result is published.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      r_seg <= {DIGITS{SEG_BLANK}};
    end else if (r_done) begin
      r_seg <= r_ovf ? {DIGITS{SEG_DASH}} : w_seg_dec;
    end else begin
      r_seg <= r_seg;
    end
  end

  assign seg = r_seg;
`endif

endmodule
